// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I(M) pipeline control unit: opcodes, ALU/MulDiv codes,
// result and immediate selects, and the ID control bundle.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Codes 16..23 select the multiply/divide unit, ordered by funct3.
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_ctl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_src_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        mul_div;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      result_src_e result_src;
      alu_ctl_e    alu_control;
   } ctrl_t;

   function automatic alu_ctl_e alu_base(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_ctl_e alu_md(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: op/funct3/funct7 to the control bundle.
// Any unsupported encoding yields an all-zero bundle with illegal set.
module ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output ctrl_t      ctrl,
   output imm_src_e   imm_src,
   output logic       illegal
);

   always_comb begin
      ctrl    = '0;
      imm_src = IMM_I;
      illegal = 1'b0;
      case (op)
         OP_R: begin
            ctrl.reg_write = 1'b1;
            if (funct7 == 7'b0000000) begin
               ctrl.alu_control = alu_base(funct3);
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               ctrl.alu_control = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               ctrl.alu_control = ALU_SRA;
            end else if (funct7 == 7'b0000001 && ENABLE_M) begin
               ctrl.mul_div     = 1'b1;
               ctrl.alu_control = alu_md(funct3);
            end else begin
               illegal = 1'b1;
            end
         end
         OP_I: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_b   = 2'b01;
            ctrl.alu_control = alu_base(funct3);
            // Shift-immediates carry funct7 in imm[11:5]; only SLLI/SRLI/SRAI patterns exist.
            if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == 7'b0100000)      ctrl.alu_control = ALU_SRA;
               else if (funct7 != 7'b0000000) illegal = 1'b1;
            end
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_MEM;
            ctrl.alu_src_b  = 2'b01;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src_b = 2'b01;
            imm_src        = IMM_S;
            if (funct3 > 3'b010) illegal = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch      = 1'b1;
            ctrl.alu_control = ALU_SUB;
            imm_src          = IMM_B;
            if (funct3[2:1] == 2'b01) illegal = 1'b1;
         end
         OP_JAL: begin
            ctrl.jump       = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = 2'b01;
            imm_src         = IMM_J;
         end
         OP_JALR: begin
            ctrl.jump       = 1'b1;
            ctrl.jalr       = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.alu_src_b  = 2'b01;
            if (funct3 != 3'b000) illegal = 1'b1;
         end
         OP_LUI: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_IMM;
            ctrl.alu_src_b  = 2'b01;
            imm_src         = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b01;
            imm_src        = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         ctrl    = '0;
         imm_src = IMM_I;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the 5-stage RV32I(M) core: ID/EX, EX/MEM, MEM/WB control registers,
// EX branch resolution and the divide occupancy counter. ALUCTL_W must be at least 5.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter int DIV_CYCLES = 32,
   parameter int ALUCTL_W   = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [6:0]          op,
   input  logic [2:0]          funct3,
   input  logic [6:0]          funct7,
   input  logic                StallE,
   input  logic                FlushE,
   input  logic                ZeroE,
   input  logic                LtE,
   input  logic                LtuE,
   output logic [2:0]          ImmSrcD,
   output logic                IllegalD,
   output logic                ALUSrcAE,
   output logic [1:0]          ALUSrcBE,
   output logic [ALUCTL_W-1:0] ALUControlE,
   output logic                MulDivE,
   output logic                DivBusyE,
   output logic                ResultSrcE0,
   output logic                PCSrcE,
   output logic                PCJalrE,
   output logic                MemWriteM,
   output logic [2:0]          MemSizeM,
   output logic                RegWriteM,
   output logic                RegWriteW,
   output logic [1:0]          ResultSrcW
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   ctrl_t             ctrl_d;
   ctrl_t             ctrl_e;
   imm_src_e          imm_src_d;
   logic [2:0]        funct3_e;
   logic [CNT_W-1:0]  cnt;
   logic              div_busy;
   logic              div_d;
   logic              taken;
   logic              reg_write_m;
   logic              mem_write_m;
   result_src_e       result_src_m;
   logic [2:0]        funct3_m;
   logic              reg_write_w;
   result_src_e       result_src_w;

   ctrl_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
      .op      (op),
      .funct3  (funct3),
      .funct7  (funct7),
      .ctrl    (ctrl_d),
      .imm_src (imm_src_d),
      .illegal (IllegalD)
   );

   assign ImmSrcD  = imm_src_d;
   assign div_d    = ctrl_d.mul_div & funct3[2];
   assign div_busy = (cnt != '0);

   // A busy divide holds EX on its own so occupancy does not depend on the hazard unit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_e   <= '0;
         funct3_e <= '0;
         cnt      <= '0;
      end else if (FlushE) begin
         ctrl_e   <= '0;
         funct3_e <= '0;
         cnt      <= '0;
      end else if (div_busy) begin
         cnt <= cnt - CNT_W'(1);
      end else if (!StallE) begin
         ctrl_e   <= ctrl_d;
         funct3_e <= funct3;
         cnt      <= div_d ? CNT_W'(DIV_CYCLES - 1) : '0;
      end
   end

   always_comb begin
      taken = 1'b0;
      case (funct3_e)
         3'b000:  taken = ZeroE;
         3'b001:  taken = ~ZeroE;
         3'b100:  taken = LtE;
         3'b101:  taken = ~LtE;
         3'b110:  taken = LtuE;
         3'b111:  taken = ~LtuE;
         default: taken = 1'b0;
      endcase
   end

   assign ALUSrcAE    = ctrl_e.alu_src_a;
   assign ALUSrcBE    = ctrl_e.alu_src_b;
   assign ALUControlE = ALUCTL_W'(ctrl_e.alu_control);
   assign MulDivE     = ctrl_e.mul_div;
   assign DivBusyE    = div_busy;
   assign ResultSrcE0 = (ctrl_e.result_src == RES_MEM);
   assign PCSrcE      = (ctrl_e.branch & taken) | ctrl_e.jump;
   assign PCJalrE     = ctrl_e.jump & ctrl_e.jalr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= RES_ALU;
         funct3_m     <= '0;
      end else if (div_busy) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= RES_ALU;
         funct3_m     <= '0;
      end else begin
         reg_write_m  <= ctrl_e.reg_write;
         mem_write_m  <= ctrl_e.mem_write;
         result_src_m <= ctrl_e.result_src;
         funct3_m     <= funct3_e;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_write_w  <= 1'b0;
         result_src_w <= RES_ALU;
      end else begin
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
      end
   end

   assign MemWriteM  = mem_write_m;
   assign MemSizeM   = funct3_m;
   assign RegWriteM  = reg_write_m;
   assign RegWriteW  = reg_write_w;
   assign ResultSrcW = result_src_w;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus random instruction streams,
// compared every cycle against a stage-slot reference model.
module tb_pipe_ctrl_unit;
   import ctrl_pkg::*;

   localparam int DIVC = 4;

   typedef struct packed {
      logic       rw;
      logic       mw;
      logic       br;
      logic       jmp;
      logic       jalr;
      logic       md;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] rs;
      logic [4:0] alu;
      logic [2:0] imm;
      logic [2:0] f3;
      logic       ill;
      logic       div;
   } bctl_t;

   logic       clock;
   logic       reset;
   logic       rst_next;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       stall_e, flush_e, zero_e, lt_e, ltu_e;

   logic [2:0] imm_src_d;
   logic       illegal_d, alu_src_a_e, mul_div_e, div_busy_e, result_src_e0;
   logic [1:0] alu_src_b_e;
   logic [4:0] alu_control_e;
   logic       pc_src_e, pc_jalr_e, mem_write_m, reg_write_m, reg_write_w;
   logic [2:0] mem_size_m;
   logic [1:0] result_src_w;

   logic [2:0] nm_imm_src_d;
   logic       nm_illegal_d, nm_alu_src_a_e, nm_mul_div_e, nm_div_busy_e, nm_result_src_e0;
   logic [1:0] nm_alu_src_b_e;
   logic [4:0] nm_alu_control_e;
   logic       nm_pc_src_e, nm_pc_jalr_e, nm_mem_write_m, nm_reg_write_m, nm_reg_write_w;
   logic [2:0] nm_mem_size_m;
   logic [1:0] nm_result_src_w;

   int n_checks = 0;
   int n_pass   = 0;

   bctl_t m_ex, m_mem, m_wb;
   int    busy_left;
   logic [4:0] base_alu [8];
   logic [4:0] md_alu [8];

   pipe_ctrl_unit #(.ENABLE_M(1'b1), .DIV_CYCLES(DIVC), .ALUCTL_W(5)) dut (
      .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
      .StallE(stall_e), .FlushE(flush_e), .ZeroE(zero_e), .LtE(lt_e), .LtuE(ltu_e),
      .ImmSrcD(imm_src_d), .IllegalD(illegal_d), .ALUSrcAE(alu_src_a_e), .ALUSrcBE(alu_src_b_e),
      .ALUControlE(alu_control_e), .MulDivE(mul_div_e), .DivBusyE(div_busy_e),
      .ResultSrcE0(result_src_e0), .PCSrcE(pc_src_e), .PCJalrE(pc_jalr_e),
      .MemWriteM(mem_write_m), .MemSizeM(mem_size_m), .RegWriteM(reg_write_m),
      .RegWriteW(reg_write_w), .ResultSrcW(result_src_w)
   );

   pipe_ctrl_unit #(.ENABLE_M(1'b0), .DIV_CYCLES(DIVC), .ALUCTL_W(5)) dut_nm (
      .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
      .StallE(stall_e), .FlushE(flush_e), .ZeroE(zero_e), .LtE(lt_e), .LtuE(ltu_e),
      .ImmSrcD(nm_imm_src_d), .IllegalD(nm_illegal_d), .ALUSrcAE(nm_alu_src_a_e),
      .ALUSrcBE(nm_alu_src_b_e), .ALUControlE(nm_alu_control_e), .MulDivE(nm_mul_div_e),
      .DivBusyE(nm_div_busy_e), .ResultSrcE0(nm_result_src_e0), .PCSrcE(nm_pc_src_e),
      .PCJalrE(nm_pc_jalr_e), .MemWriteM(nm_mem_write_m), .MemSizeM(nm_mem_size_m),
      .RegWriteM(nm_reg_write_m), .RegWriteW(nm_reg_write_w), .ResultSrcW(nm_result_src_w)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bctl_t ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                        input logic [6:0] f7, input bit en_m);
      bctl_t c;
      bit    ok;
      c  = '0;
      ok = 1'b1;
      case (o)
         OP_R: begin
            ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                    (f7 == 7'h01 && en_m);
            c.rw  = 1'b1;
            c.md  = (f7 == 7'h01);
            if (f7 == 7'h01)      c.alu = md_alu[f3];
            else if (f7 == 7'h20) c.alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
            else                  c.alu = base_alu[f3];
         end
         OP_I: begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
            c.rw   = 1'b1;
            c.srcb = 2'b01;
            c.alu  = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : base_alu[f3];
            c.imm  = IMM_I;
         end
         OP_LOAD: begin
            ok     = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            c.rw   = 1'b1;
            c.rs   = RES_MEM;
            c.srcb = 2'b01;
            c.alu  = ALU_ADD;
            c.imm  = IMM_I;
         end
         OP_STORE: begin
            ok     = (f3 <= 3'd2);
            c.mw   = 1'b1;
            c.srcb = 2'b01;
            c.alu  = ALU_ADD;
            c.imm  = IMM_S;
         end
         OP_BRANCH: begin
            ok    = !(f3 inside {3'd2, 3'd3});
            c.br  = 1'b1;
            c.alu = ALU_SUB;
            c.imm = IMM_B;
         end
         OP_JAL: begin
            c.jmp = 1'b1; c.rw = 1'b1; c.rs = RES_PC4;
            c.srca = 1'b1; c.srcb = 2'b01; c.alu = ALU_ADD; c.imm = IMM_J;
         end
         OP_JALR: begin
            ok    = (f3 == 3'd0);
            c.jmp = 1'b1; c.jalr = 1'b1; c.rw = 1'b1; c.rs = RES_PC4;
            c.srcb = 2'b01; c.alu = ALU_ADD; c.imm = IMM_I;
         end
         OP_LUI: begin
            c.rw = 1'b1; c.rs = RES_IMM; c.srcb = 2'b01; c.alu = ALU_ADD; c.imm = IMM_U;
         end
         OP_AUIPC: begin
            c.rw = 1'b1; c.srca = 1'b1; c.srcb = 2'b01; c.alu = ALU_ADD; c.imm = IMM_U;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         c     = '0;
         c.ill = 1'b1;
      end
      c.f3  = f3;
      c.div = c.md & f3[2];
      return c;
   endfunction

   function automatic bit ref_taken(input logic [2:0] f3, input logic z, input logic lt,
                                    input logic ltu);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return lt;
         3'd5:    return !lt;
         3'd6:    return ltu;
         3'd7:    return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_all();
      bctl_t d, dn;
      d  = ref_decode(op, funct3, funct7, 1'b1);
      dn = ref_decode(op, funct3, funct7, 1'b0);
      check_val("ImmSrcD", 32'(imm_src_d), 32'(d.imm));
      check_val("IllegalD", 32'(illegal_d), 32'(d.ill));
      check_val("nm_IllegalD", 32'(nm_illegal_d), 32'(dn.ill));
      check_val("ALUSrcAE", 32'(alu_src_a_e), 32'(m_ex.srca));
      check_val("ALUSrcBE", 32'(alu_src_b_e), 32'(m_ex.srcb));
      check_val("ALUControlE", 32'(alu_control_e), 32'(m_ex.alu));
      check_val("MulDivE", 32'(mul_div_e), 32'(m_ex.md));
      check_val("DivBusyE", 32'(div_busy_e), 32'(busy_left > 0));
      check_val("ResultSrcE0", 32'(result_src_e0), 32'(m_ex.rs == RES_MEM));
      check_val("PCSrcE", 32'(pc_src_e),
                32'((m_ex.br && ref_taken(m_ex.f3, zero_e, lt_e, ltu_e)) || m_ex.jmp));
      check_val("PCJalrE", 32'(pc_jalr_e), 32'(m_ex.jmp && m_ex.jalr));
      check_val("MemWriteM", 32'(mem_write_m), 32'(m_mem.mw));
      check_val("MemSizeM", 32'(mem_size_m), 32'(m_mem.f3));
      check_val("RegWriteM", 32'(reg_write_m), 32'(m_mem.rw));
      check_val("RegWriteW", 32'(reg_write_w), 32'(m_wb.rw));
      check_val("ResultSrcW", 32'(result_src_w), 32'(m_wb.rs));
   endtask

   task automatic model_clear();
      m_ex = '0; m_mem = '0; m_wb = '0; busy_left = 0;
   endtask

   task automatic model_edge();
      bctl_t d;
      bit    busy;
      d    = ref_decode(op, funct3, funct7, 1'b1);
      busy = (busy_left > 0);
      m_wb  = m_mem;
      m_mem = busy ? '0 : m_ex;
      if (flush_e) begin
         m_ex = '0;
         busy_left = 0;
      end else if (busy) begin
         busy_left--;
      end else if (!stall_e) begin
         m_ex = d;
         busy_left = d.div ? DIVC - 1 : 0;
      end
   endtask

   task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic st, input logic fl, input logic z, input logic lt,
                       input logic ltu);
      @(negedge clock);
      reset = rst_next;
      op = o; funct3 = f3; funct7 = f7;
      stall_e = st; flush_e = fl; zero_e = z; lt_e = lt; ltu_e = ltu;
      #1;
      check_all();
      @(posedge clock);
      if (!reset) model_clear();
      else model_edge();
   endtask

   task automatic idle(input logic fl = 1'b0);
      step(7'h00, 3'd0, 7'h00, 1'b0, fl, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic step_rand();
      logic [6:0] o, f7;
      int sel;
      sel = int'($urandom_range(0, 11));
      case (sel)
         0, 1, 2: o = OP_R;
         3:       o = OP_I;
         4:       o = OP_LOAD;
         5:       o = OP_STORE;
         6:       o = OP_BRANCH;
         7:       o = OP_JAL;
         8:       o = OP_JALR;
         9:       o = OP_LUI;
         10:      o = OP_AUIPC;
         default: o = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      step(o, 3'($urandom), f7, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      int busy_seen, bubbles;
      base_alu = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      md_alu   = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      reset = 1'b0; rst_next = 1'b0;
      op = '0; funct3 = '0; funct7 = '0;
      stall_e = 1'b0; flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      model_clear();

      // Random inputs under reset: every registered output must read zero.
      repeat (4) step_rand();

      // ADD after release reaches WB three edges later.
      rst_next = 1'b1;
      step(OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      #1;
      check_val("add_rw_w", 32'(reg_write_w), 32'd1);
      check_val("add_rs_w", 32'(result_src_w), 32'd0);

      // Unsigned branch pair and the reserved branch funct3.
      step(OP_BRANCH, 3'b110, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      check_val("bltu_taken", 32'(pc_src_e), 32'd1);
      step(OP_BRANCH, 3'b111, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      check_val("bgeu_not_taken", 32'(pc_src_e), 32'd0);
      step(OP_BRANCH, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      check_val("branch_f3_010_illegal", 32'(illegal_d), 32'd1);
      idle();

      // Full divide: DIVC-1 busy cycles, DIVC-1 bubbles into M, then the write arrives.
      busy_seen = 0;
      bubbles   = 0;
      step(OP_R, 3'b100, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) idle();
         #1;
         busy_seen += int'(div_busy_e);
         if (k >= 1 && k <= 3) bubbles += int'(!reg_write_m);
         if (k == 4) check_val("div_rw_m", 32'(reg_write_m), 32'd1);
      end
      check_val("div_busy_cycles", 32'(busy_seen), 32'(DIVC - 1));
      check_val("div_m_bubbles", 32'(bubbles), 32'(DIVC - 1));

      // Flush in the second busy cycle aborts the divide.
      step(OP_R, 3'b110, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      #1;
      check_val("flush_pre_busy", 32'(div_busy_e), 32'd1);
      idle(1'b1);
      #1;
      check_val("flush_abort", 32'(div_busy_e), 32'd0);
      repeat (4) begin
         idle();
         #1;
         check_val("flush_no_rw_m", 32'(reg_write_m), 32'd0);
      end

      // Without the M extension MUL is illegal and never writes back.
      step(OP_R, 3'b000, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check_val("nm_mul_illegal", 32'(nm_illegal_d), 32'd1);
      repeat (4) begin
         idle();
         #1;
         check_val("nm_mul_rw_w", 32'(nm_reg_write_w), 32'd0);
      end

      // PCJalrE follows the JALR only; flush beats stall.
      step(OP_JALR, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check_val("jalr_pcjalr", 32'(pc_jalr_e), 32'd1);
      step(OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check_val("after_jalr_pcjalr", 32'(pc_jalr_e), 32'd0);
      step(OP_JAL, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(OP_JAL, 3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check_val("flush_stall_pcsrc", 32'(pc_src_e), 32'd0);
      check_val("flush_stall_srca", 32'(alu_src_a_e), 32'd0);
      check_val("flush_stall_srcb", 32'(alu_src_b_e), 32'd0);

      // Asynchronous reset in the middle of a divide.
      step(OP_R, 3'b101, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      @(negedge clock);
      #2;
      reset    = 1'b0;
      rst_next = 1'b0;
      model_clear();
      #1;
      check_val("rst_mid_div_busy", 32'(div_busy_e), 32'd0);
      check_all();
      idle();
      rst_next = 1'b1;
      idle();
      idle();

      repeat (3000) step_rand();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control unit for the 5-stage RV32I core with optional M extension. It decodes the ID-stage instruction fields and carries control through ID/EX, EX/MEM and MEM/WB registers. It resolves all six branch conditions in EX and sequences multi-cycle divide/remainder operations with an EX-stage busy counter. It sits beside the datapath and feeds the hazard unit, which consumes `DivBusyE` and drives `StallE`/`FlushE`.

## Interface
- `ENABLE_M`, 1: decode MUL/DIV/REM (funct7 = 0000001); if 0 these encodings raise `IllegalD`.
- `DIV_CYCLES`, 32: EX occupancy of DIV/DIVU/REM/REMU in cycles; legal range 2..64.
- `ALUCTL_W`, 5: width of ALU control code.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears every register.
- `op`  in  7  ID opcode.
- `funct3`  in  3  ID funct3.
- `funct7`  in  7  ID funct7.
- `StallE`  in  1  hold ID/EX register.
- `FlushE`  in  1  clear ID/EX register (bubble).
- `ZeroE`  in  1  ALU result zero.
- `LtE`  in  1  signed A<B.
- `LtuE`  in  1  unsigned A<B.
- `ImmSrcD`  out  3  immediate format select.
- `IllegalD`  out  1  unsupported encoding in ID.
- `ALUSrcAE`  out  1  ALU A select (PC vs rs1).
- `ALUSrcBE`  out  2  ALU B select.
- `ALUControlE`  out  ALUCTL_W  ALU/MulDiv operation.
- `MulDivE`  out  1  EX op uses the multiply/divide unit.
- `DivBusyE`  out  1  divide in EX not yet complete.
- `ResultSrcE0`  out  1  EX load indicator for the hazard unit.
- `PCSrcE`  out  1  redirect PC.
- `PCJalrE`  out  1  redirect target is ALU result (JALR).
- `MemWriteM`  out  1  store enable.
- `MemSizeM`  out  3  funct3 of load/store.
- `RegWriteM`  out  1  MEM-stage register write.
- `RegWriteW`  out  1  WB-stage register write.
- `ResultSrcW`  out  2  WB result select.

## Operation
- Decode is combinational in ID. An illegal encoding drives `IllegalD`=1 and forces RegWrite, MemWrite, Branch and Jump to 0.
- ID/EX register: `FlushE` has priority and loads all-zero controls. Otherwise `StallE` holds. Otherwise it captures.
- Branch taken in EX, by funct3E:
  - 000: `ZeroE`
  - 001: `!ZeroE`
  - 100: `LtE`
  - 101: `!LtE`
  - 110: `LtuE`
  - 111: `!LtuE`
  - 010/011: illegal in ID.
- `PCSrcE` = (BranchE & taken) | JumpE.
- `PCJalrE` = JumpE & JalrE, registered from ID. It is never derived from the current ID opcode.
- Divide sequencing:
  - A divide (MulDiv with funct3[2]=1) captured into EX loads `cnt` = DIV_CYCLES-1 at the same edge.
  - While EX holds that divide and `cnt`≠0: `DivBusyE`=1 and `cnt` decrements each cycle.
  - `DivBusyE` falls when `cnt`=0. The divide then advances on the next unstalled edge.
- Multiply is single-cycle and never asserts `DivBusyE`.
- EX/MEM register: while `DivBusyE`=1 it loads a bubble (RegWrite/MemWrite/ResultSrc = 0). Otherwise it captures EX.
- MEM/WB register always captures.

## Timing
- Reset values: every output-driving register is 0 and `cnt`=0. Consequently `PCSrcE`, `DivBusyE` and all M/W controls read 0 while `reset` is low.
- Latency: ID decode to EX outputs is 1 edge, to M is 2 edges, to W is 3 edges.
- Divide occupies EX for exactly DIV_CYCLES cycles, of which DIV_CYCLES-1 have `DivBusyE` high.
- `FlushE` while a divide is busy aborts it: `cnt` is cleared and `DivBusyE` is 0 the next cycle.
- `StallE` together with `DivBusyE` is legal and does not block the `cnt` decrement.
- `FlushE` and `StallE` together: flush wins.
- Back-to-back divides: the second divide's load of `cnt` occurs at the edge where the first leaves EX.
- Asynchronous reset mid-divide clears `cnt` immediately. After release no stale busy appears.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ALU control encodings (ALUCTL_W bits);
  - ResultSrc encodings (ALU, MEM, PC+4, IMM);
  - ImmSrc encodings.
- Sub-module `ctrl_decoder` is purely combinational. It maps op/funct3/funct7 to the ID control bundle and `IllegalD`.
- Pipeline registers and the divide counter live in `pipe_ctrl_unit`.

## Test plan
- Reset low with random inputs -> all outputs 0. Release with ADD -> after 3 edges `RegWriteW`=1, `ResultSrcW`=00.
- BLTU with `LtuE`=1, `ZeroE`=0 in EX -> `PCSrcE`=1. BGEU with the same flags -> `PCSrcE`=0. funct3=010 on a branch -> `IllegalD`=1.
- DIV_CYCLES=4, DIV enters EX -> `DivBusyE` high 3 cycles, the M stage receives 3 bubbles, then the divide reaches `RegWriteM`=1.
- DIV busy and `FlushE` asserted in the 2nd busy cycle -> next cycle `DivBusyE`=0 and no `RegWriteM` for the divide.
- ENABLE_M=0 with MUL (funct7=0000001) -> `IllegalD`=1. RegWrite bubble propagates: `RegWriteW` stays 0.
- JALR in ID followed by a non-JALR op -> `PCJalrE`=1 only in the JALR's EX cycle. `FlushE`+`StallE` together -> EX controls zero.
